sitcp_tx_framer: RTL and testbench
==================================

// Module: sitcp_tx_framer
// PURPOSE
//  Streaming-source framer feeding the SiTCP TCP transmit port (TCP_TX_WR/TCP_TX_DATA, throttled by TCP_TX_FULL).
//  Buffers 32-bit user words and serialises them MSB-first into fixed-length frames, each with a 4-byte header.
//  Sits between a user data producer and WRAP_SiTCP_GMII_XC7K_32K on CLK_200M; replaces the loopback FIFO for DAQ use.
// PARAMETERS
//  FIFO_AW      4       word FIFO address width; depth = 2**FIFO_AW (16 words)
//  FRAME_WORDS  16'd64  payload words per frame (1..65535; 0 is illegal)
//  SYNC_BYTE    8'hA5   first header byte
// PORTS
//  CLK            in   1   system clock (200 MHz)
//  SYS_RSTn       in   1   asynchronous, active-low reset
//  TCP_OPEN_ACK   in   1   SiTCP connection established
//  TCP_CLOSE_REQ  in   1   SiTCP close request
//  TCP_TX_FULL    in   1   SiTCP TX almost-full
//  TCP_TX_WR      out  1   byte write strobe to SiTCP
//  TCP_TX_DATA    out  8   byte to SiTCP
//  USR_VALID      in   1   user word valid
//  USR_DATA       in   32  user word
//  USR_READY      out  1   word accepted when USR_VALID & USR_READY at CLK edge
//  FRAME_SEQ      out  8   sequence number of next/current frame
//  BUSY           out  1   high when state != IDLE
// BEHAVIOUR
//  Reset: TCP_TX_WR=0, TCP_TX_DATA=0, FRAME_SEQ=0, FIFO empty, state IDLE, byte index 0, word count 0.
//  USR_READY = TCP_OPEN_ACK & ~fifo_full (combinational). Writes are ignored while TCP_OPEN_ACK=0.
//  Frame on the wire: {SYNC_BYTE, FRAME_SEQ, FRAME_WORDS[15:8], FRAME_WORDS[7:0]},
//    then FRAME_WORDS words, each sent as [31:24],[23:16],[15:8],[7:0].
//  TCP_TX_WR/TCP_TX_DATA are registered. A byte is "sent" at an edge where the send condition holds;
//    TCP_TX_WR is high for exactly the following cycle. TCP_TX_WR=0 on every other cycle.
//  FSM:
//    IDLE -> HDR   when TCP_OPEN_ACK & ~TCP_CLOSE_REQ & fifo not empty; byte index := 0.
//    HDR: sends header byte[idx] when ~TCP_TX_FULL; after byte 3 -> DATA, idx := 0, word count := 0.
//    DATA: sends byte idx of the FIFO head word when ~TCP_TX_FULL & fifo not empty.
//      On idx=3, the FIFO head is popped in the same edge and word count increments.
//      When word count reaches FRAME_WORDS -> IDLE and FRAME_SEQ++ (wraps 8'hFF -> 8'h00).
//    FIFO empty mid-frame: stall, no byte, state held. TCP_TX_FULL high: stall in any state.
//  TCP_CLOSE_REQ: blocks new frames only; a frame already in progress continues to completion.
//  TCP_OPEN_ACK low, any state, at an edge:
//    - abort to IDLE and flush the FIFO;
//    - FRAME_SEQ := 0, idx := 0, word count := 0;
//    - no byte is sent on that edge, and TCP_TX_WR is 0 in the next cycle.
//  Simultaneous FIFO push and pop: both take effect, so occupancy is unchanged. Push when full: impossible, since READY=0.
//  Latency, empty block in IDLE: word accepted at edge N -> IDLE->HDR at N+1 -> header byte0 sent at N+2
//    -> TCP_TX_WR high during cycle N+2..N+3.
//  Throughput: 1 byte/cycle when unthrottled. There are no idle cycles between HDR and DATA or between payload words.
//  Pointers: FIFO_AW+1 bits, with the MSB used for full/empty detection. Word count: 16 bits.
// STRUCTURE
//  Package sitcp_tx_pkg: state enum {IDLE,HDR,DATA}; header byte width; localparam HDR_BYTES=4.
//  Sub-module sitcp_tx_wfifo: synchronous show-ahead word FIFO (32b x 2**FIFO_AW).
//    Ports: push, pop, din, dout, empty, full, flush.
//  Top holds the FSM, the byte mux, the counters and the output registers.
// TESTING
//  1. OPEN_ACK=1, FRAME_WORDS=2, push 32'h01020304, 32'h05060708
//     -> bytes A5 00 00 02 01 02 03 04 05 06 07 08 on 12 consecutive WR cycles; FRAME_SEQ=1 afterwards.
//  2. Same stream with TCP_TX_FULL forced high for 5 cycles after byte 3
//     -> identical byte sequence, WR low exactly 5 cycles, no byte lost or duplicated.
//  3. Push 1 word, wait 20 cycles, push 2nd (FRAME_WORDS=2)
//     -> WR low during the gap after byte 7; frame completes correctly when the 2nd word arrives.
//  4. Push 16 words with TCP_TX_FULL=1 -> USR_READY falls after the 16th accept; the 17th USR_VALID is held off.
//  5. Drop TCP_OPEN_ACK mid-DATA -> WR=0 next cycle, BUSY=0, FIFO empty, FRAME_SEQ=0.
//     On reopen the first frame has header A5 00.
//  6. Run 256 frames -> FRAME_SEQ wraps FF->00. CLOSE_REQ asserted mid-frame -> that frame completes, no new HDR starts.

Source files
------------

// File: rtl/sitcp_tx_pkg.sv
// Shared types and helpers for the SiTCP transmit framer.
package sitcp_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int HDR_BYTES = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Select byte idx of a 32-bit word, most significant byte first.
    function automatic byte_t word_byte(input logic [31:0] word, input logic [1:0] idx);
        byte_t b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sitcp_tx_wfifo.sv
// Show-ahead word FIFO: dout always presents the head word while not empty.
module sitcp_tx_wfifo
    import sitcp_tx_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards all stored words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sitcp_tx_framer.sv
// Frames buffered 32-bit user words into fixed-length, header-prefixed byte
// streams for the SiTCP TCP transmit port.
module sitcp_tx_framer
    import sitcp_tx_pkg::*;
#(
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] FRAME_WORDS = 16'd64,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        CLK,
    input  logic        SYS_RSTn,
    input  logic        TCP_OPEN_ACK,
    input  logic        TCP_CLOSE_REQ,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    input  logic        USR_VALID,
    input  logic [31:0] USR_DATA,
    output logic        USR_READY,
    output logic [7:0]  FRAME_SEQ,
    output logic        BUSY
);

    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] wcnt, wcnt_nx;
    logic [7:0]  seq, seq_nx;
    logic        send;
    byte_t       byte_nx;
    byte_t       hdr_byte;
    logic        pop;
    logic        push;
    logic        flush;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;

    assign USR_READY = TCP_OPEN_ACK & ~fifo_full;
    assign push      = USR_VALID & USR_READY;
    assign flush     = ~TCP_OPEN_ACK;
    assign FRAME_SEQ = seq;
    assign BUSY      = (state != IDLE);

    sitcp_tx_wfifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_wfifo (
        .clk   (CLK),
        .rst_n (SYS_RSTn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (USR_DATA),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Header byte selected by the current byte index.
    always_comb begin
        case (idx)
            2'd0:    hdr_byte = SYNC_BYTE;
            2'd1:    hdr_byte = seq;
            2'd2:    hdr_byte = FRAME_WORDS[15:8];
            default: hdr_byte = FRAME_WORDS[7:0];
        endcase
    end

    // Next-state, counters and byte selection; a dropped connection overrides everything.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wcnt_nx  = wcnt;
        seq_nx   = seq;
        send     = 1'b0;
        byte_nx  = '0;
        pop      = 1'b0;
        if (!TCP_OPEN_ACK) begin
            state_nx = IDLE;
            idx_nx   = '0;
            wcnt_nx  = '0;
            seq_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!TCP_CLOSE_REQ && !fifo_empty) begin
                        state_nx = HDR;
                        idx_nx   = '0;
                    end
                end
                HDR: begin
                    if (!TCP_TX_FULL) begin
                        send    = 1'b1;
                        byte_nx = hdr_byte;
                        if (idx == 2'(HDR_BYTES - 1)) begin
                            state_nx = DATA;
                            idx_nx   = '0;
                            wcnt_nx  = '0;
                        end else begin
                            idx_nx = idx + 2'd1;
                        end
                    end
                end
                DATA: begin
                    if (!TCP_TX_FULL && !fifo_empty) begin
                        send    = 1'b1;
                        byte_nx = word_byte(fifo_dout, idx);
                        idx_nx  = idx + 2'd1;
                        if (idx == 2'd3) begin
                            pop     = 1'b1;
                            wcnt_nx = wcnt + 16'd1;
                            if (wcnt_nx == FRAME_WORDS) begin
                                state_nx = IDLE;
                                seq_nx   = seq + 8'd1;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, counters and registered byte outputs.
    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            seq         <= '0;
            TCP_TX_WR   <= 1'b0;
            TCP_TX_DATA <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            wcnt      <= wcnt_nx;
            seq       <= seq_nx;
            TCP_TX_WR <= send;
            if (send)
                TCP_TX_DATA <= byte_nx;
        end
    end

endmodule

// File: tb/tb_sitcp_tx_framer.sv
// Self-checking bench for sitcp_tx_framer (two-word frames).
module tb_sitcp_tx_framer;

    localparam logic [15:0] FW = 16'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        open_ack;
    logic        close_req;
    logic        tx_full;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        usr_valid;
    logic [31:0] usr_data;
    logic        usr_ready;
    logic [7:0]  frame_seq;
    logic        busy;

    always #5 clk = ~clk;

    sitcp_tx_framer #(
        .FIFO_AW     (4),
        .FRAME_WORDS (FW),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK           (clk),
        .SYS_RSTn      (rst_n),
        .TCP_OPEN_ACK  (open_ack),
        .TCP_CLOSE_REQ (close_req),
        .TCP_TX_FULL   (tx_full),
        .TCP_TX_WR     (tx_wr),
        .TCP_TX_DATA   (tx_data),
        .USR_VALID     (usr_valid),
        .USR_DATA      (usr_data),
        .USR_READY     (usr_ready),
        .FRAME_SEQ     (frame_seq),
        .BUSY          (busy)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         wpos = 0;
    logic [7:0] mseq = 8'h00;
    int         mframes = 0;
    int         wr_cnt = 0;
    int         gap = 0;
    int         last_gap = 0;
    bit         wrap_seen = 1'b0;
    bit         last_acc = 1'b0;
    logic [7:0] prev_seq = 8'h00;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        exp_wr;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic [7:0]  exp_seq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: each accepted word extends the expected byte stream.
    task automatic model_push(input logic [31:0] w);
        if (wpos == 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(mseq);
            exp_q.push_back(FW[15:8]);
            exp_q.push_back(FW[7:0]);
        end
        for (int b = 3; b >= 0; b--)
            exp_q.push_back(w[8*b +: 8]);
        wpos++;
        if (wpos == int'(FW)) begin
            wpos = 0;
            mseq = mseq + 8'd1;
            mframes++;
        end
    endtask

    task automatic model_abort();
        exp_q.delete();
        wpos = 0;
        mseq = 8'h00;
    endtask

    // Advance to the next falling edge and score any byte written at the rising edge.
    task automatic step();
        @(negedge clk);
        if (tx_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_byte: got %0h, expected no byte", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            wr_cnt++;
            last_gap = gap;
            gap = 0;
        end else begin
            gap++;
        end
        if (prev_seq == 8'hFF && frame_seq == 8'h00 && open_ack)
            wrap_seen = 1'b1;
        prev_seq = frame_seq;
    endtask

    task automatic tick();
        #1;
        last_acc = usr_valid && usr_ready;
        if (last_acc)
            model_push(usr_data);
        step();
    endtask

    task automatic push_word(input logic [31:0] w);
        usr_valid = 1'b1;
        usr_data  = w;
        tick();
        usr_valid = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(wr_cnt), 32'(target));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        int   acc;
        int   first_block;
        int   n;
        int   fstart;

        tbl[0]  = '{1'b1, 32'h01020304, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 32'h05060708, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 8'hA5, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 8'h02, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 8'h01, 1'b1, 8'h00};
        tbl[7]  = '{1'b0, 32'h0,        1'b1, 8'h02, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 32'h0,        1'b1, 8'h03, 1'b1, 8'h00};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 8'h04, 1'b1, 8'h00};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 8'h05, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 8'h06, 1'b1, 8'h00};
        tbl[12] = '{1'b0, 32'h0,        1'b1, 8'h07, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 32'h0,        1'b1, 8'h08, 1'b0, 8'h01};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 8'h01};

        rst_n     = 1'b0;
        open_ack  = 1'b0;
        close_req = 1'b0;
        tx_full   = 1'b0;
        usr_valid = 1'b0;
        usr_data  = '0;

        // Reset state
        repeat (3) step();
        check("rst_wr",    32'(tx_wr),     32'd0);
        check("rst_data",  32'(tx_data),   32'd0);
        check("rst_seq",   32'(frame_seq), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(usr_ready), 32'd0);
        rst_n    = 1'b1;
        open_ack = 1'b1;
        tick();
        check("ready_open", 32'(usr_ready), 32'd1);

        // Basic frame, cycle by cycle
        wr_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            usr_valid = tbl[i].valid;
            usr_data  = tbl[i].data;
            tick();
            check($sformatf("t1_wr[%0d]", i), 32'(tx_wr), 32'(tbl[i].exp_wr));
            if (tbl[i].exp_wr)
                check($sformatf("t1_data[%0d]", i), 32'(tx_data), 32'(tbl[i].exp_data));
            check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("t1_seq[%0d]", i), 32'(frame_seq), 32'(tbl[i].exp_seq));
        end
        check("t1_count", 32'(wr_cnt), 32'd12);

        // Throttle for five cycles after the fourth byte
        wr_cnt = 0;
        push_word(32'h01020304);
        push_word(32'h05060708);
        wait_wr(4, 20, "t2_hdr");
        tx_full = 1'b1;
        repeat (5) tick();
        check("t2_hold", 32'(wr_cnt), 32'd4);
        tx_full = 1'b0;
        wait_wr(5, 5, "t2_resume");
        check("t2_gap", 32'(last_gap), 32'd5);
        wait_wr(12, 20, "t2_count");
        wait_drain(10, "t2_drain");
        check("t2_total", 32'(wr_cnt), 32'd12);
        check("t2_seq", 32'(frame_seq), 32'd2);

        // Starved mid-frame
        wr_cnt = 0;
        push_word(32'hDEADBEEF);
        wait_wr(8, 20, "t3_first");
        repeat (20) tick();
        check("t3_starve_wr", 32'(wr_cnt), 32'd8);
        check("t3_starve_busy", 32'(busy), 32'd1);
        push_word(32'hCAFEF00D);
        wait_wr(12, 20, "t3_second");
        wait_drain(10, "t3_drain");
        check("t3_seq", 32'(frame_seq), 32'(mseq));

        // Fill the FIFO while throttled
        wr_cnt = 0;
        acc = 0;
        first_block = -1;
        tx_full = 1'b1;
        usr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            usr_data = $urandom;
            tick();
            if (last_acc) acc++;
            else if (first_block < 0) first_block = i;
        end
        check("t4_accepts", 32'(acc), 32'd16);
        check("t4_block_at", 32'(first_block), 32'd16);
        check("t4_ready_low", 32'(usr_ready), 32'd0);
        check("t4_no_wr", 32'(wr_cnt), 32'd0);
        usr_valid = 1'b0;
        tx_full = 1'b0;
        wait_drain(400, "t4_drain");
        check("t4_bytes", 32'(wr_cnt), 32'd96);

        // Connection drop mid-payload
        wr_cnt = 0;
        push_word(32'h11223344);
        push_word(32'h55667788);
        wait_wr(6, 20, "t5_pre");
        open_ack = 1'b0;
        model_abort();
        tick();
        check("t5_wr", 32'(tx_wr), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_seq", 32'(frame_seq), 32'd0);
        check("t5_ready", 32'(usr_ready), 32'd0);
        repeat (3) tick();
        open_ack = 1'b1;
        repeat (10) tick();
        check("t5_flushed", 32'(busy), 32'd0);
        check("t5_quiet", 32'(wr_cnt), 32'd6);
        push_word(32'h99AABBCC);
        push_word(32'hDDEEFF00);
        wait_drain(40, "t5_reopen");
        check("t5_bytes", 32'(wr_cnt), 32'd18);
        check("t5_seq_after", 32'(frame_seq), 32'd1);

        // Random traffic through a sequence wrap
        fstart = mframes;
        n = 0;
        while (mframes - fstart < 256 && n < 20000) begin
            usr_valid = ($urandom_range(9) < 7);
            usr_data  = $urandom;
            tx_full   = ($urandom_range(4) == 0);
            tick();
            n++;
        end
        usr_valid = 1'b0;
        tx_full = 1'b0;
        check("t6_frames", 32'(mframes - fstart >= 256), 32'd1);
        if (wpos != 0) push_word($urandom);
        wait_drain(400, "t6_drain");
        check("t6_wrap", 32'(wrap_seen), 32'd1);
        check("t6_seq", 32'(frame_seq), 32'(mseq));

        // Close request mid-frame
        wr_cnt = 0;
        push_word(32'hA1B2C3D4);
        wait_wr(2, 20, "t6_close_pre");
        close_req = 1'b1;
        push_word(32'hE5F60718);
        wait_drain(40, "t6_close_done");
        check("t6_close_bytes", 32'(wr_cnt), 32'd12);
        push_word(32'h0BADCAFE);
        repeat (20) tick();
        check("t6_close_nowr", 32'(wr_cnt), 32'd12);
        check("t6_close_idle", 32'(busy), 32'd0);
        close_req = 1'b0;
        wait_drain(40, "t6_reopen_drain");
        check("t6_final_bytes", 32'(wr_cnt), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
